lane_deskew_buffer: RTL and testbench

//  Multi-lane RX deskew stage after the per-lane elastic buffers; all lanes share the local clock.

---
 rtl/lane_deskew_pkg.sv | 15 +
 rtl/lane_deskew_fifo.sv | 58 +++++
 rtl/lane_deskew_buffer.sv | 151 +++++++++++++++
 tb/tb_lane_deskew_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_deskew_pkg.sv
// Shared types and K28.5 comma definitions for the lane deskew buffer.
package lane_deskew_pkg;

    localparam int unsigned SYM_W = 10;

    localparam logic [SYM_W-1:0] COM_RDN = 10'h0FA;
    localparam logic [SYM_W-1:0] COM_RDP = 10'h305;

    typedef enum logic [0:0] {HUNT, ALIGNED} deskew_state_t;

    function automatic logic is_com(input logic [SYM_W-1:0] sym);
        return (sym == COM_RDN) || (sym == COM_RDP);
    endfunction

endpackage

// File: rtl/lane_deskew_fifo.sv
// Per-lane symbol FIFO with wrap-bit pointers, combinational head and synchronous flush.
module lane_deskew_fifo
    import lane_deskew_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SYM_W,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head     = mem_q[rd_ptr_q[AW-1:0]];
        do_push  = push && !full && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop && !empty) rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/lane_deskew_buffer.sv
// Multi-lane deskew: hunts for a common K28.5 on every lane, then releases lanes in lock-step.
module lane_deskew_buffer
    import lane_deskew_pkg::*;
#(
    parameter  int unsigned NUM_LANES  = 4,
    parameter  int unsigned DATA_WIDTH = SYM_W,
    parameter  int unsigned DEPTH      = 16,
    parameter  int unsigned MAX_SKEW   = 8,
    localparam int unsigned SKEW_W     = $clog2(MAX_SKEW + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
    output logic                            out_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
    output logic                            aligned,
    output logic [SKEW_W-1:0]               skew_cnt,
    output logic                            deskew_err,
    output logic                            align_lost,
    output logic                            overflow
);

    localparam int unsigned BUS_W = NUM_LANES * DATA_WIDTH;

    deskew_state_t state_q, state_d;
    logic [SKEW_W-1:0] cnt_q, cnt_d, skew_cnt_q, skew_cnt_d, skew_now;
    logic hunt_act_q, hunt_act_d;
    logic out_valid_q, out_valid_d;
    logic deskew_err_q, deskew_err_d;
    logic align_lost_q, align_lost_d;
    logic overflow_q, overflow_d;
    logic [BUS_W-1:0] data_out_q, data_out_d, heads;
    logic [NUM_LANES-1:0] lane_full, lane_empty, lane_com, lane_pop;
    logic lane_push, flush, pop_all;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] head;

        lane_deskew_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (lane_push),
            .pop   (lane_pop[i]),
            .flush (flush),
            .din   (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .head  (head),
            .full  (lane_full[i]),
            .empty (lane_empty[i])
        );

        assign heads[i*DATA_WIDTH +: DATA_WIDTH] = head;
        assign lane_com[i] = !lane_empty[i] && is_com(SYM_W'(head));
    end

    // Hunt/aligned control; overflow outranks deskew and alignment-loss handling.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hunt_act_d   = hunt_act_q;
        skew_cnt_d   = skew_cnt_q;
        data_out_d   = data_out_q;
        out_valid_d  = 1'b0;
        deskew_err_d = 1'b0;
        align_lost_d = 1'b0;
        overflow_d   = 1'b0;
        lane_pop     = '0;
        flush        = 1'b0;
        pop_all      = 1'b0;
        lane_push    = in_valid && !(|lane_full);
        skew_now     = hunt_act_q ? cnt_q : '0;

        if (in_valid && (|lane_full)) begin
            flush      = 1'b1;
            overflow_d = 1'b1;
            state_d    = HUNT;
            hunt_act_d = 1'b0;
            cnt_d      = '0;
        end else if (state_q == HUNT) begin
            lane_pop = ~lane_empty & ~lane_com;
            if (|lane_com) begin
                if (&lane_com) begin
                    pop_all    = 1'b1;
                    state_d    = ALIGNED;
                    skew_cnt_d = skew_now;
                    hunt_act_d = 1'b0;
                    cnt_d      = '0;
                end else if (skew_now == SKEW_W'(MAX_SKEW)) begin
                    lane_pop     = '0;
                    flush        = 1'b1;
                    deskew_err_d = 1'b1;
                    hunt_act_d   = 1'b0;
                    cnt_d        = '0;
                end else begin
                    hunt_act_d = 1'b1;
                    cnt_d      = skew_now + SKEW_W'(1);
                end
            end
        end else if (!(|lane_empty)) begin
            if ((|lane_com) && !(&lane_com)) begin
                flush        = 1'b1;
                align_lost_d = 1'b1;
                state_d      = HUNT;
            end else begin
                pop_all = 1'b1;
            end
        end

        if (pop_all) begin
            lane_pop    = '1;
            out_valid_d = 1'b1;
            data_out_d  = heads;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            cnt_q        <= '0;
            hunt_act_q   <= 1'b0;
            skew_cnt_q   <= '0;
            data_out_q   <= '0;
            out_valid_q  <= 1'b0;
            deskew_err_q <= 1'b0;
            align_lost_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hunt_act_q   <= hunt_act_d;
            skew_cnt_q   <= skew_cnt_d;
            data_out_q   <= data_out_d;
            out_valid_q  <= out_valid_d;
            deskew_err_q <= deskew_err_d;
            align_lost_q <= align_lost_d;
            overflow_q   <= overflow_d;
        end
    end

    assign aligned    = (state_q == ALIGNED);
    assign out_valid  = out_valid_q;
    assign data_out   = data_out_q;
    assign skew_cnt   = skew_cnt_q;
    assign deskew_err = deskew_err_q;
    assign align_lost = align_lost_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_lane_deskew_buffer.sv
// Scoreboard bench for lane_deskew_buffer; a second instance with MAX_SKEW=15 exposes overflow.
module tb_lane_deskew_buffer;
    import lane_deskew_pkg::*;

    localparam int unsigned NL = 4;
    localparam int unsigned DW = 10;
    localparam int unsigned WW = NL * DW;

    logic          clk = 1'b0;
    logic          rst, in_valid;
    logic [WW-1:0] data_in;
    logic          out_valid, aligned, deskew_err, align_lost, overflow;
    logic [WW-1:0] data_out;
    logic [3:0]    skew_cnt;
    logic          out_valid_b, aligned_b, deskew_err_b, align_lost_b, overflow_b;
    logic [WW-1:0] data_out_b;
    logic [3:0]    skew_cnt_b;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] sb [NL][$];
    logic [NL-1:0] armed;

    always #5 clk = ~clk;

    lane_deskew_buffer #(.NUM_LANES(NL), .DATA_WIDTH(DW), .DEPTH(16), .MAX_SKEW(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .out_valid(out_valid), .data_out(data_out), .aligned(aligned), .skew_cnt(skew_cnt),
        .deskew_err(deskew_err), .align_lost(align_lost), .overflow(overflow)
    );

    lane_deskew_buffer #(.NUM_LANES(NL), .DATA_WIDTH(DW), .DEPTH(16), .MAX_SKEW(15)) u_dut15 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .out_valid(out_valid_b), .data_out(data_out_b), .aligned(aligned_b), .skew_cnt(skew_cnt_b),
        .deskew_err(deskew_err_b), .align_lost(align_lost_b), .overflow(overflow_b)
    );

    // Lane symbol: garbage before its COM cycle, COM at it, unique data after.
    function automatic logic [DW-1:0] sym_at(int lane, int cyc, int com_cyc);
        if (cyc < com_cyc) return DW'(32'h100 + lane);
        if (cyc == com_cyc) return COM_RDN;
        return DW'(32'h200 + cyc * 16 + lane);
    endfunction

    function automatic logic [WW-1:0] word_at(int cyc, int c0, int c1, int c2, int c3);
        return {sym_at(3, cyc, c3), sym_at(2, cyc, c2), sym_at(1, cyc, c1), sym_at(0, cyc, c0)};
    endfunction

    task automatic sb_clear();
        for (int i = 0; i < NL; i++) sb[i].delete();
        armed = '0;
    endtask

    task automatic sb_pop(output logic [WW-1:0] w);
        for (int i = 0; i < NL; i++) begin
            if (sb[i].size() > 0) w[i*DW +: DW] = sb[i].pop_front();
            else w[i*DW +: DW] = 'x;
        end
    endtask

    // Applies one cycle of input; each lane's stream is expected from its first COM onward.
    task automatic drive(input logic v, input logic [WW-1:0] w);
        logic [DW-1:0] s;
        in_valid = v;
        data_in  = w;
        if (v && !rst) begin
            for (int i = 0; i < NL; i++) begin
                s = w[i*DW +: DW];
                if (armed[i] || is_com(s)) begin
                    armed[i] = 1'b1;
                    sb[i].push_back(s);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0);
        rst = 1'b0;
        sb_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0);
        drive(1'b0, '0);
        vectors++;
        if ({out_valid, aligned, deskew_err, align_lost, overflow} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_flags got %b exp 00000", {out_valid, aligned, deskew_err, align_lost, overflow});
        end
        vectors++;
        if (data_out !== '0) begin miscompares++; $display("FAIL rst_data got %h exp 0", data_out); end
        vectors++;
        if (skew_cnt !== 4'd0) begin miscompares++; $display("FAIL rst_skew got %0d exp 0", skew_cnt); end
        vectors++;
        if ({out_valid_b, aligned_b, deskew_err_b, align_lost_b, overflow_b, skew_cnt_b, data_out_b} !== '0) begin
            miscompares++;
            $display("FAIL rst_aux got %h exp 0", {out_valid_b, aligned_b, skew_cnt_b, data_out_b});
        end
        rst = 1'b0;
        sb_clear();
    endtask

    task automatic test_zero_skew();
        logic [WW-1:0] exp_w;
        do_reset();
        drive(1'b1, {NL{COM_RDN}});
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL zs_early got %b exp 0", out_valid); end
        drive(1'b1, {NL{10'h1CC}});
        vectors++;
        if ({out_valid, aligned} !== 2'b11) begin
            miscompares++; $display("FAIL zs_first got %b exp 11", {out_valid, aligned});
        end
        vectors++;
        if (skew_cnt !== 4'd0) begin miscompares++; $display("FAIL zs_skew got %0d exp 0", skew_cnt); end
        sb_pop(exp_w);
        vectors++;
        if (data_out !== exp_w) begin miscompares++; $display("FAIL zs_com got %h exp %h", data_out, exp_w); end
        for (int k = 2; k < 14; k++) begin
            drive(k < 10, word_at(k, 0, 0, 0, 0));
            if (out_valid) begin
                sb_pop(exp_w);
                vectors++;
                if (data_out !== exp_w) begin miscompares++; $display("FAIL zs_data got %h exp %h", data_out, exp_w); end
            end
        end
        vectors++;
        if (sb[0].size() != 0) begin miscompares++; $display("FAIL zs_drain left %0d exp 0", sb[0].size()); end
    endtask

    task automatic test_skew3();
        logic [WW-1:0] exp_w;
        int n_out = 0;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(k < 12, word_at(k, 0, 0, 3, 0));
            if (out_valid) begin
                if (n_out == 0) begin
                    vectors++;
                    if ({aligned, skew_cnt} !== {1'b1, 4'd3}) begin
                        miscompares++; $display("FAIL sk3_skew got %b/%0d exp 1/3", aligned, skew_cnt);
                    end
                end
                sb_pop(exp_w);
                n_out++;
                vectors++;
                if (data_out !== exp_w) begin miscompares++; $display("FAIL sk3_data got %h exp %h", data_out, exp_w); end
            end
        end
        vectors++;
        if (n_out != 9) begin miscompares++; $display("FAIL sk3_count got %0d exp 9", n_out); end
    endtask

    task automatic test_deskew_err();
        logic [WW-1:0] exp_w;
        int errs = 0, err_cyc = -1, al_seen = 0, n_out = 0;
        do_reset();
        for (int k = 0; k < 15; k++) begin
            drive(1'b1, word_at(k, 0, 9, 0, 0));
            if (deskew_err) begin errs++; if (err_cyc < 0) err_cyc = k + 1; end
            if (aligned) al_seen = 1;
        end
        vectors++;
        if (errs != 1 || err_cyc != 10) begin
            miscompares++; $display("FAIL de_pulse got %0d@%0d exp 1@10", errs, err_cyc);
        end
        vectors++;
        if (al_seen != 0) begin miscompares++; $display("FAIL de_aligned got %0d exp 0", al_seen); end
        sb_clear();
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, word_at(k, 0, 2, 0, 0));
            if (out_valid) begin
                if (n_out == 0) begin
                    vectors++;
                    if ({aligned, skew_cnt} !== {1'b1, 4'd2}) begin
                        miscompares++; $display("FAIL de_retry got %b/%0d exp 1/2", aligned, skew_cnt);
                    end
                end
                sb_pop(exp_w);
                n_out++;
                vectors++;
                if (data_out !== exp_w) begin miscompares++; $display("FAIL de_data got %h exp %h", data_out, exp_w); end
            end
        end
        vectors++;
        if (n_out != 9) begin miscompares++; $display("FAIL de_count got %0d exp 9", n_out); end
    endtask

    task automatic test_align_lost();
        logic [WW-1:0] exp_w, w;
        int lost = 0, lost_cyc = -1, n_out = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            w = word_at(k, 0, 0, 0, 0);
            if (k == 6) begin
                w[0 +: DW]  = COM_RDP;
                w[DW +: DW] = COM_RDP;
            end
            drive(1'b1, w);
            if (align_lost) begin lost++; lost_cyc = k + 1; end
            if (out_valid) begin
                sb_pop(exp_w);
                vectors++;
                if (data_out !== exp_w) begin miscompares++; $display("FAIL al_data got %h exp %h", data_out, exp_w); end
            end
        end
        vectors++;
        if (lost != 1 || lost_cyc != 8) begin
            miscompares++; $display("FAIL al_pulse got %0d@%0d exp 1@8", lost, lost_cyc);
        end
        vectors++;
        if (aligned !== 1'b0) begin miscompares++; $display("FAIL al_fall got %b exp 0", aligned); end
        sb_clear();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, word_at(k, 0, 0, 0, 0));
            if (out_valid) begin
                sb_pop(exp_w);
                n_out++;
                vectors++;
                if (data_out !== exp_w) begin miscompares++; $display("FAIL al_re_data got %h exp %h", data_out, exp_w); end
            end
        end
        vectors++;
        if (n_out != 7 || aligned !== 1'b1) begin
            miscompares++; $display("FAIL al_realign got %0d/%b exp 7/1", n_out, aligned);
        end
    endtask

    task automatic test_overflow();
        int err_cyc = -1, errs = 0, ovfs = 0;
        int ovf_b_cyc = -1, ovfs_b = 0, errs_b = 0, al_b = 0;
        do_reset();
        for (int k = 0; k < 25; k++) begin
            drive(1'b1, word_at(k, 0, 0, 0, 1000));
            if (deskew_err) begin errs++; if (err_cyc < 0) err_cyc = k + 1; end
            if (overflow) ovfs++;
            if (overflow_b) begin ovfs_b++; if (ovf_b_cyc < 0) ovf_b_cyc = k + 1; end
            if (deskew_err_b) errs_b++;
            if (aligned_b || out_valid_b) al_b = 1;
        end
        vectors++;
        if (errs != 1 || err_cyc != 10) begin
            miscompares++; $display("FAIL ov_err got %0d@%0d exp 1@10", errs, err_cyc);
        end
        vectors++;
        if (ovfs != 0) begin miscompares++; $display("FAIL ov_main got %0d exp 0", ovfs); end
        vectors++;
        if (ovfs_b != 1 || ovf_b_cyc != 17) begin
            miscompares++; $display("FAIL ov_pulse got %0d@%0d exp 1@17", ovfs_b, ovf_b_cyc);
        end
        vectors++;
        if (errs_b != 0 || al_b != 0) begin
            miscompares++; $display("FAIL ov_aux got err %0d al %0d exp 0 0", errs_b, al_b);
        end
    endtask

    task automatic test_reset_mid_and_gaps();
        logic [WW-1:0] exp_w;
        int n_out = 0, n_push = 0;
        logic v;
        do_reset();
        for (int k = 0; k < 8; k++) drive(1'b1, word_at(k, 0, 0, 3, 0));
        vectors++;
        if ({aligned, skew_cnt} !== {1'b1, 4'd3}) begin
            miscompares++; $display("FAIL rm_pre got %b/%0d exp 1/3", aligned, skew_cnt);
        end
        rst = 1'b1;
        drive(1'b1, word_at(8, 0, 0, 3, 0));
        rst = 1'b0;
        vectors++;
        if ({out_valid, aligned, deskew_err, align_lost, overflow, skew_cnt, data_out} !== '0) begin
            miscompares++;
            $display("FAIL rm_zero got %b %0d %h exp all 0", {out_valid, aligned, deskew_err, align_lost, overflow}, skew_cnt, data_out);
        end
        sb_clear();
        for (int k = 0; k < 34; k++) begin
            v = (k < 30) && (((k / 3) % 2) == 0);
            if (v) n_push++;
            drive(v, word_at(k, 0, 0, 0, 0));
            if (out_valid) begin
                sb_pop(exp_w);
                n_out++;
                vectors++;
                if (data_out !== exp_w) begin miscompares++; $display("FAIL gap_data got %h exp %h", data_out, exp_w); end
            end
        end
        vectors++;
        if (n_out != n_push || n_push != 15) begin
            miscompares++; $display("FAIL gap_count got %0d exp %0d", n_out, n_push);
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        armed    = '0;
        test_reset();
        test_zero_skew();
        test_skew3();
        test_deskew_err();
        test_align_lost();
        test_overflow();
        test_reset_mid_and_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
